frame_buffer_writer: RTL and testbench

Double-buffered pixel store between the thermal sensor readout logic and `spi_controller`. It accepts a byte stream of one thermal frame over a valid/ready handshake and writes it into the back bank. On frame completion it swaps banks, but only while the SPI side is not mid-transfer. The front bank is exposed as an asynchronous read port that drives `spi_controller`'s `data` / `data_address` pair directly.

---
 rtl/frame_buffer_writer.sv | 208 ++++++++++++++++++++
 tb/tb_frame_buffer_writer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_writer.sv
// ---------------------------------------------------------------------------
// frame_buffer_writer
//
// Double-buffered pixel store that sits between the thermal sensor readout
// and spi_controller. One sensor frame arrives as a byte stream over a
// valid/ready handshake and is written into the back bank. Once the frame is
// complete, the banks swap, but only while the SPI side is not in the middle
// of a transfer. The front bank is exposed as a combinational read port.
//
// Ports:
//   hf_clk          system clock, rising edge
//   reset           asynchronous, active-high reset
//   frame_start     single-cycle pulse marking a new sensor frame
//   pixel_data      incoming byte
//   pixel_valid     pixel_data is valid
//   pixel_ready     block accepts a byte this cycle
//   read_lock       SPI transfer in progress (SPI cs); blocks the bank swap
//   rd_address      front-bank read address
//   rd_data         front-bank byte, combinational from rd_address
//   frame_valid     at least one complete frame has reached the front
//   frame_done      one-cycle pulse on each bank swap
//   dropped_frames  saturating count of aborted or discarded frames
// ---------------------------------------------------------------------------
module frame_buffer_writer #(
    parameter int FRAME_BYTES = 1536,
    parameter int ADDR_WIDTH  = 14,
    parameter int DROP_WIDTH  = 8
) (
    input  logic                  hf_clk,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic [7:0]            pixel_data,
    input  logic                  pixel_valid,
    output logic                  pixel_ready,
    input  logic                  read_lock,
    input  logic [ADDR_WIDTH-1:0] rd_address,
    output logic [7:0]            rd_data,
    output logic                  frame_valid,
    output logic                  frame_done,
    output logic [DROP_WIDTH-1:0] dropped_frames
);

    // Index width that covers exactly one bank of FRAME_BYTES entries.
    localparam int IDX_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;

    // Address of the final byte of a frame.
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_BYTES - 1);

    // FRAME_BYTES may equal 2^ADDR_WIDTH, so it needs one extra bit.
    localparam logic [ADDR_WIDTH:0] FRAME_LEN = (ADDR_WIDTH + 1)'(FRAME_BYTES);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WRITE        = 2'd1,
        SWAP_PENDING = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   write_address;
    logic                    display_bank;

    // Two banks of pixel storage. They have no reset, so they map onto RAM.
    logic [7:0]              bank0 [FRAME_BYTES];
    logic [7:0]              bank1 [FRAME_BYTES];

    // Per-cycle control decisions made by the next-state logic.
    logic                    write_en;
    logic                    addr_clear;
    logic                    addr_inc;
    logic                    do_swap;
    logic                    drop_inc;

    logic [IDX_W-1:0]        write_index;
    logic [IDX_W-1:0]        read_index;
    logic                    read_in_range;

    // State register. Reset abandons any frame in flight, including one that
    // is waiting for its swap.
    always_ff @(posedge hf_clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control decode. In WRITE, frame_start takes priority
    // over a byte arriving in the same cycle: that byte belongs to the
    // abandoned frame, so it is discarded instead of being written at
    // address 0 of the new one.
    always_comb begin
        state_next  = state;
        pixel_ready = 1'b0;
        write_en    = 1'b0;
        addr_clear  = 1'b0;
        addr_inc    = 1'b0;
        do_swap     = 1'b0;
        drop_inc    = 1'b0;

        case (state)
            IDLE: begin
                if (frame_start) begin
                    addr_clear = 1'b1;
                    state_next = WRITE;
                end
            end

            WRITE: begin
                pixel_ready = 1'b1;
                if (frame_start) begin
                    addr_clear = 1'b1;
                    drop_inc   = 1'b1;
                end else if (pixel_valid) begin
                    write_en = 1'b1;
                    if (write_address == LAST_ADDR) begin
                        addr_clear = 1'b1;
                        state_next = SWAP_PENDING;
                    end else begin
                        addr_inc = 1'b1;
                    end
                end
            end

            SWAP_PENDING: begin
                // The completed frame stays parked here for as long as SPI
                // is reading, so the front bank cannot change under a
                // transfer. A new frame arriving meanwhile has nowhere to go
                // and is counted as dropped.
                if (!read_lock) begin
                    do_swap    = 1'b1;
                    state_next = IDLE;
                end else if (frame_start) begin
                    drop_inc = 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Write pointer. It is cleared on the last byte as well, so it never
    // moves past the end of the frame.
    always_ff @(posedge hf_clk or posedge reset) begin
        if (reset) begin
            write_address <= '0;
        end else if (addr_clear) begin
            write_address <= '0;
        end else if (addr_inc) begin
            write_address <= write_address + 1'b1;
        end
    end

    // Bank selection and frame status. frame_done is registered, so it is
    // high for exactly the cycle after the swap edge.
    always_ff @(posedge hf_clk or posedge reset) begin
        if (reset) begin
            display_bank <= 1'b0;
            frame_valid  <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= do_swap;
            if (do_swap) begin
                display_bank <= ~display_bank;
                frame_valid  <= 1'b1;
            end
        end
    end

    // Dropped-frame counter. It holds at all-ones instead of wrapping.
    always_ff @(posedge hf_clk or posedge reset) begin
        if (reset) begin
            dropped_frames <= '0;
        end else if (drop_inc && (dropped_frames != {DROP_WIDTH{1'b1}})) begin
            dropped_frames <= dropped_frames + 1'b1;
        end
    end

    assign write_index = write_address[IDX_W-1:0];

    // Back-bank write port. The back bank is always the one not on display.
    always_ff @(posedge hf_clk) begin
        if (write_en) begin
            if (display_bank) begin
                bank0[write_index] <= pixel_data;
            end else begin
                bank1[write_index] <= pixel_data;
            end
        end
    end

    assign read_index    = rd_address[IDX_W-1:0];
    assign read_in_range = ({1'b0, rd_address} < FRAME_LEN);

    // Front-bank read port. It is purely combinational so spi_controller
    // sees the byte in the same cycle it presents the address. The output is
    // zero until the first swap, because before that neither bank holds a
    // complete frame.
    always_comb begin
        rd_data = 8'h00;
        if (frame_valid && read_in_range) begin
            rd_data = display_bank ? bank1[read_index] : bank0[read_index];
        end
    end

endmodule

// File: tb/tb_frame_buffer_writer.sv
// ---------------------------------------------------------------------------
// tb_frame_buffer_writer
//
// Randomised bench for frame_buffer_writer. A behavioural model tracks two
// byte banks, which one is on display, and whether a frame is being written
// or is waiting to be shown. One compare process checks every DUT output
// against that model on each falling edge. Directed literal checks pin the
// model to hand-derived values.
// ---------------------------------------------------------------------------
module tb_frame_buffer_writer;

    localparam int FB       = 1536;
    localparam int AW       = 14;
    localparam int DW       = 8;
    localparam int DROP_MAX = (1 << DW) - 1;

    logic          hf_clk = 1'b0;
    logic          reset = 1'b0;
    logic          frame_start = 1'b0;
    logic [7:0]    pixel_data = 8'h00;
    logic          pixel_valid = 1'b0;
    logic          pixel_ready;
    logic          read_lock = 1'b0;
    logic [AW-1:0] rd_address = '0;
    logic [7:0]    rd_data;
    logic          frame_valid;
    logic          frame_done;
    logic [DW-1:0] dropped_frames;

    int compare_count = 0;
    int fail_count = 0;
    int done_count = 0;
    bit rand_rd = 1'b1;

    // Bytes the bench sends for the current frame.
    logic [7:0] frame_data [FB];

    // Behavioural model state.
    logic [7:0] m_bank [2][FB];
    int  m_front = 0;
    int  m_addr = 0;
    bit  m_writing = 1'b0;
    bit  m_pending = 1'b0;
    bit  m_valid = 1'b0;
    bit  m_done = 1'b0;
    int  m_drop = 0;

    frame_buffer_writer #(
        .FRAME_BYTES (FB),
        .ADDR_WIDTH  (AW),
        .DROP_WIDTH  (DW)
    ) dut (
        .hf_clk         (hf_clk),
        .reset          (reset),
        .frame_start    (frame_start),
        .pixel_data     (pixel_data),
        .pixel_valid    (pixel_valid),
        .pixel_ready    (pixel_ready),
        .read_lock      (read_lock),
        .rd_address     (rd_address),
        .rd_data        (rd_data),
        .frame_valid    (frame_valid),
        .frame_done     (frame_done),
        .dropped_frames (dropped_frames)
    );

    // 10 ns clock: rising edges at 5, 15, ...; falling edges at 10, 20, ...
    always #5 hf_clk = ~hf_clk;

    task automatic check_output(input string name, input int actual, input int expected);
        compare_count++;
        if (actual != expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int model_rd(input int addr);
        if (m_valid && addr < FB) return int'(m_bank[m_front][addr]);
        return 0;
    endfunction

    function automatic void note_drop();
        if (m_drop < DROP_MAX) m_drop++;
    endfunction

    // Model update from the inputs seen at each rising edge, plus an
    // immediate clear when reset rises.
    task automatic model_step();
        if (reset) begin
            m_writing = 1'b0;
            m_pending = 1'b0;
            m_front   = 0;
            m_valid   = 1'b0;
            m_done    = 1'b0;
            m_drop    = 0;
            m_addr    = 0;
        end else begin
            m_done = 1'b0;
            if (m_pending) begin
                if (!read_lock) begin
                    m_front   = 1 - m_front;
                    m_valid   = 1'b1;
                    m_done    = 1'b1;
                    m_pending = 1'b0;
                end else if (frame_start) begin
                    note_drop();
                end
            end else if (m_writing) begin
                if (frame_start) begin
                    m_addr = 0;
                    note_drop();
                end else if (pixel_valid) begin
                    m_bank[1 - m_front][m_addr] = pixel_data;
                    m_addr++;
                    if (m_addr == FB) begin
                        m_addr    = 0;
                        m_writing = 1'b0;
                        m_pending = 1'b1;
                    end
                end
            end else if (frame_start) begin
                m_writing = 1'b1;
                m_addr    = 0;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge hf_clk or posedge reset);
            model_step();
        end
    end

    // Compare process: all outputs against the model on every falling edge.
    initial begin
        forever begin
            @(negedge hf_clk);
            check_output("pixel_ready", pixel_ready, m_writing);
            check_output("frame_valid", frame_valid, m_valid);
            check_output("frame_done", frame_done, m_done);
            check_output("dropped_frames", dropped_frames, m_drop);
            check_output("rd_data", rd_data, model_rd(int'(rd_address)));
            if (frame_done) done_count++;
        end
    end

    // Drive one cycle of inputs. Inputs change 2 ns after a rising edge and
    // are sampled at the following rising edge.
    task automatic apply_stimulus(input logic fs, input logic pv, input logic [7:0] pd, input logic rl);
        frame_start = fs;
        pixel_valid = pv;
        pixel_data  = pd;
        read_lock   = rl;
        if (rand_rd) rd_address = AW'($urandom_range(0, FB + 40));
        @(posedge hf_clk);
        #2;
    endtask

    task automatic idle_cycles(input int n, input logic rl);
        for (int k = 0; k < n; k++) apply_stimulus(1'b0, 1'b0, 8'h00, rl);
    endtask

    // Send n bytes of frame_data with roughly valid_pct percent of cycles valid.
    task automatic send_bytes(input int n, input int valid_pct, input logic rl);
        int i = 0;
        int guard = 0;
        logic pv;
        while (i < n && guard < 20 * n + 100) begin
            pv = ($urandom_range(1, 100) <= valid_pct);
            apply_stimulus(1'b0, pv, pv ? frame_data[i] : 8'($urandom), rl);
            if (pv) i++;
            guard++;
        end
        if (i < n) check_output("send_bytes_budget", i, n);
    endtask

    task automatic read_literal(input string name, input int addr, input int expected);
        rand_rd    = 1'b0;
        rd_address = AW'(addr);
        #1;
        check_output(name, rd_data, expected);
    endtask

    // Read the whole front bank one address per cycle and compare it with
    // the bytes the bench sent.
    task automatic sweep_front(input string name);
        rand_rd = 1'b0;
        for (int a = 0; a < FB; a++) begin
            rd_address = AW'(a);
            #1;
            check_output($sformatf("%s[%0d]", name, a), rd_data, int'(frame_data[a]));
            apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
        end
        rand_rd = 1'b1;
    endtask

    task automatic do_reset();
        #1 reset = 1'b1;
        idle_cycles(3, 1'b0);
        reset = 1'b0;
        idle_cycles(2, 1'b0);
    endtask

    initial begin
        int done_before;

        // Reset values.
        do_reset();
        rand_rd = 1'b0;
        read_literal("reset_rd_0", 0, 8'h00);
        read_literal("reset_rd_700", 700, 8'h00);
        check_output("reset_frame_valid", frame_valid, 0);
        check_output("reset_pixel_ready", pixel_ready, 0);
        check_output("reset_dropped", dropped_frames, 0);
        rand_rd = 1'b1;

        // One frame, no lock, 1 byte per cycle.
        $display("[TB] single frame");
        for (int i = 0; i < FB; i++) frame_data[i] = 8'((i + 1) & 8'hFF);
        apply_stimulus(1'b1, 1'b1, 8'hEE, 1'b0);
        send_bytes(FB, 100, 1'b0);
        idle_cycles(3, 1'b0);
        check_output("frame1_done_count", done_count, 1);
        check_output("frame1_valid", frame_valid, 1);
        read_literal("frame1_rd_0", 0, 8'h01);
        read_literal("frame1_rd_1", 1, 8'h02);
        read_literal("frame1_rd_254", 254, 8'hFF);
        read_literal("frame1_rd_255", 255, 8'h00);
        read_literal("frame1_rd_1535", 1535, 8'h00);
        read_literal("frame1_rd_1536", 1536, 8'h00);
        rand_rd = 1'b1;

        // Swap held off by read_lock; a frame_start while pending is dropped.
        $display("[TB] locked swap");
        for (int i = 0; i < FB; i++) frame_data[i] = 8'((i * 7 + 3) & 8'hFF);
        apply_stimulus(1'b1, 1'b0, 8'h00, 1'b1);
        send_bytes(FB, 100, 1'b1);
        idle_cycles(10, 1'b1);
        apply_stimulus(1'b1, 1'b0, 8'h00, 1'b1);
        idle_cycles(10, 1'b1);
        check_output("lock_done_count", done_count, 1);
        check_output("lock_dropped", dropped_frames, 1);
        read_literal("lock_old_rd_0", 0, 8'h01);
        apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
        check_output("lock_release_done", frame_done, 1);
        read_literal("lock_new_rd_0", 0, 8'h03);
        read_literal("lock_new_rd_1", 1, 8'h0A);
        idle_cycles(2, 1'b0);
        check_output("lock_done_count2", done_count, 2);
        rand_rd = 1'b1;

        // Restart mid-frame.
        $display("[TB] restart mid-frame");
        do_reset();
        done_before = done_count;
        for (int i = 0; i < FB; i++) frame_data[i] = 8'hAA;
        apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
        send_bytes(100, 100, 1'b0);
        apply_stimulus(1'b1, 1'b1, 8'hAA, 1'b0);
        for (int i = 0; i < FB; i++) frame_data[i] = 8'h55;
        send_bytes(FB, 100, 1'b0);
        idle_cycles(3, 1'b0);
        check_output("restart_dropped", dropped_frames, 1);
        check_output("restart_done_count", done_count - done_before, 1);
        sweep_front("restart_front");

        // Dropped-frame counter saturation.
        $display("[TB] drop saturation");
        apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < DROP_MAX + 5; k++) apply_stimulus(1'b1, 1'b1, 8'($urandom), 1'b0);
        check_output("drop_saturated", dropped_frames, DROP_MAX);
        do_reset();

        // Bursty handshake with garbage presented while not ready.
        $display("[TB] bursty frame");
        for (int i = 0; i < FB; i++) frame_data[i] = 8'($urandom);
        idle_cycles(1, 1'b0);
        for (int k = 0; k < 5; k++) apply_stimulus(1'b0, 1'b1, 8'($urandom), 1'b0);
        apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
        send_bytes(FB, 45, 1'b0);
        for (int k = 0; k < 6; k++) apply_stimulus(1'b0, 1'b1, 8'($urandom), 1'b0);
        idle_cycles(1, 1'b0);
        sweep_front("bursty_front");

        // Asynchronous reset in the middle of a frame.
        $display("[TB] async reset mid-frame");
        for (int i = 0; i < FB; i++) frame_data[i] = 8'($urandom);
        apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
        send_bytes(500, 100, 1'b0);
        rand_rd    = 1'b0;
        rd_address = '0;
        pixel_valid = 1'b0;
        #1 reset = 1'b1;
        #1;
        check_output("areset_pixel_ready", pixel_ready, 0);
        check_output("areset_frame_valid", frame_valid, 0);
        check_output("areset_frame_done", frame_done, 0);
        check_output("areset_dropped", dropped_frames, 0);
        check_output("areset_rd_data", rd_data, 8'h00);
        idle_cycles(2, 1'b0);
        reset = 1'b0;
        rand_rd = 1'b1;
        idle_cycles(2, 1'b0);
        done_before = done_count;
        for (int i = 0; i < FB; i++) frame_data[i] = 8'($urandom);
        apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
        send_bytes(FB, 80, 1'b0);
        idle_cycles(3, 1'b0);
        check_output("areset_new_done", done_count - done_before, 1);
        check_output("areset_new_valid", frame_valid, 1);
        sweep_front("areset_front");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule
